// File: rtl/scratch_wb_pkg.sv
// Shared types for the 128-bit Wishbone bus initiator:
// FSM states, cycle-type codes and request/response bundles.
package scratch_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef struct packed {
        logic        we;
        logic [15:0] sel;
        logic [1:0]  len;
        logic [7:0]  tag;
    } req_t;

    typedef struct packed {
        logic         last;
        logic         err;
        logic [127:0] dat;
    } rsp_t;

endpackage

// File: rtl/scratch_wb_master128.sv
// Wishbone-style 128-bit bus initiator: one client request becomes
// a single access or an incrementing burst of up to 4 beats, with timeout.
module scratch_wb_master128
    import scratch_wb_pkg::*;
#(
    parameter int AWID  = 18,
    parameter int TMO   = 255,
    parameter int DRAIN = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_i,
    output logic            req_rdy_o,
    input  logic            req_we_i,
    input  logic [AWID-1:0] req_adr_i,
    input  logic [15:0]     req_sel_i,
    input  logic [1:0]      req_len_i,
    input  logic [7:0]      req_tag_i,
    input  logic [127:0]    wdat_i,
    output logic            wdat_rd_o,
    output logic            rsp_vld_o,
    output logic [127:0]    rsp_dat_o,
    output logic [7:0]      rsp_tag_o,
    output logic            rsp_last_o,
    output logic            rsp_err_o,
    output logic            cyc_o,
    output logic            stb_o,
    output logic            cs_o,
    output logic            we_o,
    output logic [15:0]     sel_o,
    output logic [AWID-1:0] adr_o,
    output logic [127:0]    dat_o,
    output logic [2:0]      cti_o,
    output logic [7:0]      bndx_o,
    input  logic            adack_i,
    input  logic            ack_i,
    input  logic [127:0]    dat_i,
    input  logic [7:0]      bndx_i
);

    localparam int CW = 10;
    localparam int BW = AWID - 4;

    state_t          r_state;
    state_t          w_next;
    req_t            r_req;
    rsp_t            r_rsp;
    logic            r_rsp_vld;
    logic            r_wdat_rd;
    logic [BW-1:0]   r_adr;
    logic [1:0]      r_beat;
    logic [CW-1:0]   r_cnt;
    logic [127:0]    r_dat;
    logic            w_last;
    logic            w_tmo;
    logic            w_dend;
    logic            w_unused;

    assign w_last   = (r_beat == r_req.len);
    assign w_tmo    = (r_cnt == CW'(TMO));
    assign w_dend   = (r_cnt == CW'(DRAIN - 1));
    assign w_unused = ^{adack_i, bndx_i, req_adr_i[3:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (req_i) w_next = ST_BEAT;
            ST_BEAT: begin
                if (ack_i)      w_next = ST_DRAIN;
                else if (w_tmo) w_next = ST_ERR;
            end
            ST_DRAIN: if (w_dend) w_next = w_last ? ST_IDLE : ST_BEAT;
            ST_ERR:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // r_cnt is the ack timeout in BEAT and the gap timer in DRAIN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_req     <= '0;
            r_rsp     <= '0;
            r_rsp_vld <= 1'b0;
            r_wdat_rd <= 1'b0;
            r_adr     <= '0;
            r_beat    <= '0;
            r_cnt     <= '0;
            r_dat     <= '0;
        end else begin
            r_rsp_vld <= 1'b0;
            r_wdat_rd <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_i) begin
                        r_req  <= '{we: req_we_i, sel: req_sel_i,
                                    len: req_len_i, tag: req_tag_i};
                        r_adr  <= req_adr_i[AWID-1:4];
                        r_beat <= '0;
                        r_cnt  <= '0;
                        r_dat  <= wdat_i;
                    end
                end
                ST_BEAT: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (ack_i) begin
                        r_cnt     <= '0;
                        r_rsp_vld <= ~r_req.we | w_last;
                        r_wdat_rd <= r_req.we;
                        r_rsp     <= '{last: w_last, err: 1'b0,
                                       dat: r_req.we ? 128'd0 : dat_i};
                    end else if (w_tmo) begin
                        r_rsp_vld <= 1'b1;
                        r_rsp     <= '{last: 1'b1, err: 1'b1, dat: 128'd0};
                    end
                end
                ST_DRAIN: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_dend) begin
                        r_cnt <= '0;
                        r_adr <= r_adr + BW'(1);
                        r_dat <= wdat_i;
                        if (!w_last) r_beat <= r_beat + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_rdy_o  = (r_state == ST_IDLE);
    assign stb_o      = (r_state == ST_BEAT);
    assign cs_o       = stb_o;
    assign cyc_o      = stb_o | ((r_state == ST_DRAIN) & ~w_last);
    assign cti_o      = !stb_o               ? CTI_CLASSIC :
                        (r_req.len == 2'd0)  ? CTI_CLASSIC :
                        w_last               ? CTI_EOB     : CTI_INCR;
    assign we_o       = r_req.we;
    assign sel_o      = r_req.sel;
    assign adr_o      = {r_adr, 4'h0};
    assign dat_o      = r_dat;
    assign bndx_o     = r_req.tag;
    assign wdat_rd_o  = r_wdat_rd;
    assign rsp_vld_o  = r_rsp_vld;
    assign rsp_dat_o  = r_rsp.dat;
    assign rsp_last_o = r_rsp.last;
    assign rsp_err_o  = r_rsp.err;
    assign rsp_tag_o  = r_req.tag;

endmodule

// File: tb/tb_scratch_wb_master128.sv
// Bench for scratch_wb_master128: responder model on the bus side,
// table vectors, random transactions and reset/back-to-back sequences.
module tb_scratch_wb_master128;
    import scratch_wb_pkg::*;

    localparam int AWID  = 18;
    localparam int TMO   = 255;
    localparam int DRAIN = 4;

    typedef struct {
        bit          we;
        logic [17:0] adr;
        logic [15:0] sel;
        logic [1:0]  len;
        logic [7:0]  tag;
        int          lat;
        bit          echo;
        int          exp_nrsp;
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic [127:0] dat;
        logic [7:0]   tag;
        logic         last;
        logic         err;
    } mrsp_t;

    typedef struct {
        logic [17:0]  adr;
        logic [2:0]   cti;
        logic [127:0] dat;
        logic [7:0]   tag;
        logic         we;
        logic [15:0]  sel;
        int           t;
    } mbeat_t;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         req_i = 1'b0;
    logic         req_rdy_o;
    logic         req_we_i = 1'b0;
    logic [17:0]  req_adr_i = '0;
    logic [15:0]  req_sel_i = '0;
    logic [1:0]   req_len_i = '0;
    logic [7:0]   req_tag_i = '0;
    logic [127:0] wdat_i = '0;
    logic         wdat_rd_o;
    logic         rsp_vld_o;
    logic [127:0] rsp_dat_o;
    logic [7:0]   rsp_tag_o;
    logic         rsp_last_o;
    logic         rsp_err_o;
    logic         cyc_o, stb_o, cs_o, we_o;
    logic [15:0]  sel_o;
    logic [17:0]  adr_o;
    logic [127:0] dat_o;
    logic [2:0]   cti_o;
    logic [7:0]   bndx_o;
    logic         adack_i = 1'b0;
    logic         ack_i = 1'b0;
    logic [127:0] dat_i = '0;
    logic [7:0]   bndx_i = '0;

    int n_vec = 0;
    int n_err = 0;

    logic [127:0] rmem  [16384];
    logic [127:0] mem_m [16384];
    logic [127:0] wbeat [4];
    int           widx = 0;
    int           cur_lat = 0;
    bit           cur_echo = 0;
    int           s_cnt = 0;
    int           echo_cd = 0;
    int           lat_eff;
    logic [13:0]  ridx;

    mrsp_t  rsp_q[$];
    mbeat_t beat_q[$];
    int     n_wrd = 0;
    int     cyc_n = 0;
    int     stb_len = 0;
    bit     prev_stb = 0;
    bit     done = 0;
    bit     pend_rdy = 0;
    bit     rdy_after = 0;

    scratch_wb_master128 #(.AWID(AWID), .TMO(TMO), .DRAIN(DRAIN)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_i(req_i), .req_rdy_o(req_rdy_o), .req_we_i(req_we_i),
        .req_adr_i(req_adr_i), .req_sel_i(req_sel_i), .req_len_i(req_len_i),
        .req_tag_i(req_tag_i), .wdat_i(wdat_i), .wdat_rd_o(wdat_rd_o),
        .rsp_vld_o(rsp_vld_o), .rsp_dat_o(rsp_dat_o), .rsp_tag_o(rsp_tag_o),
        .rsp_last_o(rsp_last_o), .rsp_err_o(rsp_err_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .cs_o(cs_o), .we_o(we_o),
        .sel_o(sel_o), .adr_o(adr_o), .dat_o(dat_o), .cti_o(cti_o),
        .bndx_o(bndx_o), .adack_i(adack_i), .ack_i(ack_i),
        .dat_i(dat_i), .bndx_i(bndx_i)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Responder: read ack after 3 strobe cycles, write after 1, optional echo
    always @(negedge clk) begin
        ack_i = 1'b0;
        dat_i = {$urandom, $urandom, $urandom, $urandom};
        if (!rst_ni) begin
            s_cnt   = 0;
            echo_cd = 0;
        end else begin
            if (echo_cd > 0) begin
                echo_cd--;
                if (echo_cd == 0) ack_i = 1'b1;
            end
            if (stb_o) begin
                s_cnt++;
                lat_eff = (cur_lat == 0) ? (we_o ? 1 : 3) : cur_lat;
                if (cur_lat >= 0 && s_cnt == lat_eff) begin
                    ack_i = 1'b1;
                    ridx  = adr_o[17:4];
                    if (we_o) begin
                        for (int b = 0; b < 16; b++)
                            if (sel_o[b]) rmem[ridx][8*b +: 8] = dat_o[8*b +: 8];
                    end else begin
                        dat_i = rmem[ridx];
                    end
                    if (cur_echo) echo_cd = 2;
                end
            end else begin
                s_cnt = 0;
            end
        end
    end

    // Monitor and write-data client
    always @(negedge clk) begin
        cyc_n++;
        if (pend_rdy) begin
            rdy_after = req_rdy_o;
            pend_rdy  = 0;
        end
        if (rst_ni) begin
            if (rsp_vld_o) begin
                rsp_q.push_back('{rsp_dat_o, rsp_tag_o, rsp_last_o, rsp_err_o});
                if (rsp_last_o) done = 1;
                if (rsp_err_o) pend_rdy = 1;
            end
            if (wdat_rd_o) begin
                n_wrd++;
                if (widx < 3) widx++;
            end
            if (stb_o) begin
                if (!prev_stb) begin
                    beat_q.push_back('{adr_o, cti_o, dat_o, bndx_o, we_o, sel_o, cyc_n});
                    stb_len = 1;
                end else begin
                    stb_len++;
                end
            end
        end
        wdat_i   = wbeat[widx];
        prev_stb = stb_o;
    end

    task automatic model_write(input logic [13:0] base, input int nb,
                               input logic [15:0] sel);
        logic [13:0] ix;
        for (int i = 0; i < nb; i++) begin
            ix = 14'(base + 14'(i));
            for (int b = 0; b < 16; b++)
                if (sel[b]) mem_m[ix][8*b +: 8] = wbeat[i][8*b +: 8];
        end
    endtask

    task automatic prep(input int lat, input bit echo);
        int guard;
        for (int i = 0; i < 4; i++)
            wbeat[i] = {$urandom, $urandom, $urandom, $urandom};
        widx = 0;
        cur_lat = lat;
        cur_echo = echo;
        guard = 0;
        while (!req_rdy_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        @(negedge clk);
        rsp_q.delete();
        beat_q.delete();
        n_wrd = 0;
        done = 0;
        rdy_after = 0;
    endtask

    task automatic drive(input bit we, input logic [17:0] adr, input logic [15:0] sel,
                         input logic [1:0] len, input logic [7:0] tag);
        req_we_i  = we;
        req_adr_i = adr;
        req_sel_i = sel;
        req_len_i = len;
        req_tag_i = tag;
        req_i     = 1'b1;
    endtask

    task automatic run_txn(input vec_t v);
        logic [13:0] base;
        int nb, guard, lat_exp;
        logic [2:0] cti_e;
        base = v.adr[17:4];
        prep(v.lat, v.echo);
        drive(v.we, v.adr, v.sel, v.len, v.tag);
        @(posedge clk);
        #1 req_i = 1'b0;
        guard = 0;
        while (!done && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("done", done, 1);
        guard = 0;
        while (!req_rdy_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        nb = (v.lat < 0) ? 1 : int'(v.len) + 1;
        lat_exp = (v.lat < 0) ? TMO + 1 : (v.lat > 0) ? v.lat : (v.we ? 1 : 3);
        chk("nrsp", rsp_q.size(), v.exp_nrsp);
        chk("nbeat", beat_q.size(), nb);
        chk("stb_len", stb_len, lat_exp);
        chk("n_wrd", n_wrd, (v.we && v.lat >= 0) ? nb : 0);
        for (int i = 0; i < beat_q.size() && i < nb; i++) begin
            cti_e = (v.len == 0) ? CTI_CLASSIC : (i == int'(v.len)) ? CTI_EOB : CTI_INCR;
            chk("adr", beat_q[i].adr, {14'(base + 14'(i)), 4'h0});
            chk("cti", beat_q[i].cti, cti_e);
            chk("bndx", beat_q[i].tag, v.tag);
            chk("we", beat_q[i].we, v.we);
            chk("sel", beat_q[i].sel, v.sel);
            if (v.we) chk("wdat", beat_q[i].dat, wbeat[i]);
            if (i > 0) chk("gap", beat_q[i].t - beat_q[i-1].t, lat_exp + DRAIN);
        end
        for (int k = 0; k < rsp_q.size(); k++) begin
            chk("rtag", rsp_q[k].tag, v.tag);
            chk("rerr", rsp_q[k].err, v.exp_err);
            chk("rlast", rsp_q[k].last, k == rsp_q.size() - 1);
            chk("rdat", rsp_q[k].dat,
                (v.we || v.exp_err) ? 128'd0 : mem_m[14'(base + 14'(k))]);
        end
        if (v.exp_err) chk("rdy_after_err", rdy_after, 1);
        if (v.we && v.lat >= 0) model_write(base, nb, v.sel);
    endtask

    vec_t tbl[8];
    vec_t rv;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        for (int i = 0; i < 16384; i++) begin
            rmem[i]  = {$urandom, $urandom, $urandom, $urandom};
            mem_m[i] = rmem[i];
        end
        rmem[16'h10]  = 128'h00112233445566778899AABBCCDDEEFF;
        mem_m[16'h10] = 128'h00112233445566778899AABBCCDDEEFF;
        wbeat[0] = '0; wbeat[1] = '0; wbeat[2] = '0; wbeat[3] = '0;

        tbl[0] = '{0, 18'h00100, 16'hFFFF, 2'd0, 8'h5A, 0,   0, 1, 0};
        tbl[1] = '{1, 18'h3FFE0, 16'hFFFF, 2'd3, 8'h21, 0,   0, 1, 0};
        tbl[2] = '{0, 18'h3FFE0, 16'hFFFF, 2'd3, 8'h22, 0,   0, 4, 0};
        tbl[3] = '{0, 18'h00200, 16'hFFFF, 2'd0, 8'h33, -1,  0, 1, 1};
        tbl[4] = '{1, 18'h00400, 16'h00FF, 2'd1, 8'h44, 0,   1, 1, 0};
        tbl[5] = '{0, 18'h00405, 16'hFFFF, 2'd2, 8'h45, 0,   1, 3, 0};
        tbl[6] = '{0, 18'h00400, 16'hFFFF, 2'd0, 8'h46, 256, 0, 1, 0};
        tbl[7] = '{1, 18'h00800, 16'hFFFF, 2'd2, 8'h47, -1,  0, 1, 1};

        repeat (3) @(negedge clk);
        chk("rst_rdy", req_rdy_o, 1);
        chk("rst_cyc", cyc_o, 0);
        chk("rst_stb", stb_o, 0);
        chk("rst_vld", rsp_vld_o, 0);
        chk("rst_wrd", wdat_rd_o, 0);
        chk("rst_adr", adr_o, 0);
        chk("rst_cti", cti_o, 0);
        chk("rst_dat", dat_o, 0);
        rst_ni = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i]);
            if (i == 0 && rsp_q.size() > 0)
                chk("t1_dat", rsp_q[0].dat, 128'h00112233445566778899AABBCCDDEEFF);
        end

        // Reset while the third beat of a 4-beat read is on the bus
        prep(0, 0);
        drive(0, 18'h01000, 16'hFFFF, 2'd3, 8'h77);
        @(posedge clk);
        #1 req_i = 1'b0;
        guard = 0;
        while (!(beat_q.size() == 3 && stb_o) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("t5_pre_stb", stb_o, 1);
        #1 rst_ni = 1'b0;
        #1;
        chk("t5_cyc", cyc_o, 0);
        chk("t5_stb", stb_o, 0);
        chk("t5_vld", rsp_vld_o, 0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        repeat (6) @(negedge clk);
        chk("t5_rdy", req_rdy_o, 1);
        chk("t5_cyc_after", cyc_o, 0);
        chk("t5_nrsp", rsp_q.size(), 2);

        // Back-to-back: 2-beat read, then a single write held on req_i
        prep(0, 0);
        drive(0, 18'h02000, 16'hFFFF, 2'd1, 8'hA1);
        @(posedge clk);
        #1;
        chk("t6_busy", req_rdy_o, 0);
        drive(1, 18'h03010, 16'hF0F0, 2'd0, 8'hB2);
        guard = 0;
        while (!req_rdy_o && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("t6_first_done", rsp_q.size(), 2);
        @(posedge clk);
        #1 req_i = 1'b0;
        guard = 0;
        while (rsp_q.size() < 3 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        repeat (6) @(negedge clk);
        chk("t6_nrsp", rsp_q.size(), 3);
        if (rsp_q.size() == 3) begin
            chk("t6_tag0", rsp_q[0].tag, 8'hA1);
            chk("t6_tag1", rsp_q[1].tag, 8'hA1);
            chk("t6_tag2", rsp_q[2].tag, 8'hB2);
            chk("t6_last", {rsp_q[0].last, rsp_q[1].last, rsp_q[2].last}, 3'b011);
            chk("t6_dat0", rsp_q[0].dat, mem_m[14'h200]);
            chk("t6_dat1", rsp_q[1].dat, mem_m[14'h201]);
            chk("t6_dat2", rsp_q[2].dat, 0);
        end
        model_write(14'h301, 1, 16'hF0F0);

        for (int n = 0; n < 30; n++) begin
            rv.we       = 1'($urandom_range(0, 1));
            rv.adr      = 18'($urandom);
            rv.sel      = 16'($urandom);
            rv.len      = 2'($urandom_range(0, 3));
            rv.tag      = 8'($urandom);
            rv.lat      = $urandom_range(0, 5);
            rv.echo     = 1'($urandom_range(0, 1));
            rv.exp_nrsp = rv.we ? 1 : int'(rv.len) + 1;
            rv.exp_err  = 0;
            run_txn(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
